// File: rtl/ub_pkg.sv
// Shared definitions for the dual-port unified buffer.
// Provides the default lane geometry, the word-width helper and the clear-FSM state type.
package ub_pkg;

    localparam int unsigned UB_LANES  = 8;
    localparam int unsigned UB_LANE_W = 8;

    // Word width from lane count and lane width.
    function automatic int unsigned ub_word_w(input int unsigned lanes, input int unsigned lane_w);
        return lanes * lane_w;
    endfunction

    typedef enum logic {
        UB_IDLE  = 1'b0,
        UB_CLEAR = 1'b1
    } ub_clr_state_t;

endpackage

// File: rtl/ub_clear_ctrl.sv
// Zero-fill engine for the unified buffer: walks every address once, one per cycle.
// Ports:
//   clk, rst_n   clock / async active-low reset
//   clr_req_i    single-cycle start pulse (ignored while clearing)
//   clr_busy_o   clear in progress; also the array clear-write enable
//   clr_done_o   one-cycle pulse coincident with clr_busy_o falling
//   clr_we_o     array clear-write enable
//   clr_addr_o   address being zeroed this cycle
module ub_clear_ctrl
    import ub_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req_i,
    output logic              clr_busy_o,
    output logic              clr_done_o,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_addr_o
);

    // One extra bit so the step past DEPTH-1 is visible as a carry.
    localparam int unsigned CNT_W = ADDR_W + 1;

    ub_clr_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Next-state and output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            UB_IDLE: begin
                if (clr_req_i) begin
                    state_d = UB_CLEAR;
                    cnt_d   = '0;
                end
            end
            UB_CLEAR: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_d[ADDR_W]) begin
                    state_d = UB_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = UB_IDLE;
        endcase
        busy_d = (state_d == UB_CLEAR);
    end

    // State, counter and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= UB_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign clr_busy_o = busy_q;
    assign clr_done_o = done_q;
    assign clr_we_o   = busy_q;
    assign clr_addr_o = cnt_q[ADDR_W-1:0];

endmodule

// File: rtl/unified_buffer_dp.sv
// Simple-dual-port unified buffer (one write, one read port per cycle) with per-lane
// write strobes, write-first collision bypass, 1- or 2-cycle read latency and zero-fill.
// Ports:
//   clk, rst_n                          clock / async active-low reset
//   wr_en, wr_addr, wr_data, wr_strb    write port (strobe per lane)
//   rd_en, rd_addr                      read request
//   rd_data, rd_valid                   read result, valid RD_LATENCY cycles after request
//   clr_req, clr_busy, clr_done         zero-fill start / in progress / completion pulse
module unified_buffer_dp
    import ub_pkg::*;
#(
    parameter  int unsigned ADDR_W     = 10,
    parameter  int unsigned LANES      = UB_LANES,
    parameter  int unsigned LANE_W     = UB_LANE_W,
    parameter  int unsigned RD_LATENCY = 1,
    localparam int unsigned W          = ub_word_w(LANES, LANE_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [W-1:0]      wr_data,
    input  logic [LANES-1:0]  wr_strb,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [W-1:0]      rd_data,
    output logic              rd_valid,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [W-1:0]      mem_q [DEPTH];
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_fire;
    logic              rd_fire;
    logic [W-1:0]      rd_word;
    logic [W-1:0]      s1_data_q;
    logic              s1_valid_q;

    ub_clear_ctrl #(
        .ADDR_W(ADDR_W)
    ) u_clear (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_req_i (clr_req),
        .clr_busy_o(clr_busy),
        .clr_done_o(clr_done),
        .clr_we_o  (clr_we),
        .clr_addr_o(clr_addr)
    );

    // Host accesses are locked out for the whole clear.
    assign wr_fire = wr_en & ~clr_busy;
    assign rd_fire = rd_en & ~clr_busy;

    // Array write port: the clear engine has priority, otherwise strobed lanes only.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_addr] <= '0;
        end else if (wr_fire) begin
            for (int i = 0; i < LANES; i++) begin
                if (wr_strb[i]) begin
                    mem_q[wr_addr][i*LANE_W +: LANE_W] <= wr_data[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    // Write-first bypass: a same-address write overrides only its strobed lanes.
    always_comb begin
        rd_word = mem_q[rd_addr];
        if (wr_fire && (wr_addr == rd_addr)) begin
            for (int i = 0; i < LANES; i++) begin
                if (wr_strb[i]) begin
                    rd_word[i*LANE_W +: LANE_W] = wr_data[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    // First read stage; data holds when no read is launched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
        end else begin
            s1_valid_q <= rd_fire;
            if (rd_fire) begin
                s1_data_q <= rd_word;
            end
        end
    end

    generate
        if (RD_LATENCY >= 2) begin : g_lat2
            logic [W-1:0] s2_data_q;
            logic         s2_valid_q;

            // Output register; in-flight data is already captured so later writes cannot alter it.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s2_valid_q <= 1'b0;
                    s2_data_q  <= '0;
                end else begin
                    s2_valid_q <= s1_valid_q;
                    if (s1_valid_q) begin
                        s2_data_q <= s1_data_q;
                    end
                end
            end

            assign rd_data  = s2_data_q;
            assign rd_valid = s2_valid_q;
        end else begin : g_lat1
            assign rd_data  = s1_data_q;
            assign rd_valid = s1_valid_q;
        end
    endgenerate

endmodule

// File: doc/unified_buffer_dp.md
Name: unified_buffer_dp

Overview:
- Simple-dual-port unified buffer: one write port and one read port, active in the same cycle. Successor to the single-port 8-byte unified buffer.
- Stores activations and partial results as LANES x LANE_W words.
- Adds per-lane write strobes, write-first collision bypass, a configurable read latency with a valid flag, and a hardware zero-fill (clear) engine.
- Sits between the input DMA/host side and the systolic array feeders.

Parameters:
- ADDR_W, 10, address width; depth DEPTH = 2**ADDR_W words.
- LANES, 8, number of byte lanes per word.
- LANE_W, 8, bits per lane; word width W = LANES*LANE_W.
- RD_LATENCY, 1, read latency in cycles; legal values 1 or 2 (2 adds an output register).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  W  write data; lane i = bits [i*LANE_W +: LANE_W].
- wr_strb  in  LANES  per-lane write enable.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  W  read data.
- rd_valid  out  1  rd_data valid this cycle.
- clr_req  in  1  single-cycle pulse that starts zero-fill of the whole array.
- clr_busy  out  1  clear in progress.
- clr_done  out  1  one-cycle pulse when the clear completes.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active low.
- Reset values: rd_data=0, rd_valid=0, clr_busy=0, clr_done=0, clear counter=0, read pipeline flushed.
- Memory array is not reset; its contents are undefined after power-up until written or cleared.
- Write: at a rising edge with wr_en=1 and clr_busy=0, each lane i with wr_strb[i]=1 is updated. Lanes with strobe 0 keep their old value.
- wr_en=1 with wr_strb=0 is a legal no-op.
- Read, RD_LATENCY=1: rd_en=1 at edge N gives rd_data and rd_valid=1 after edge N+1.
- Read, RD_LATENCY=2: rd_data and rd_valid=1 appear one cycle later.
- When no read is issued: rd_valid=0 and rd_data holds its last value.
- Reads are fully pipelined: back-to-back reads give one result per cycle.
- Collision (rd_en, wr_en, rd_addr==wr_addr in the same cycle) is write-first per lane: strobed lanes return wr_data, unstrobed lanes return the old contents.
- A write in a later cycle does not alter a read already in flight (matters for RD_LATENCY=2).
- Clear FSM states: IDLE and CLEAR.
  - IDLE -> CLEAR on clr_req=1. The counter loads 0 and clr_busy rises the next cycle.
  - In CLEAR, one address is zeroed per cycle (all lanes), addresses 0..DEPTH-1 in order. Duration is exactly DEPTH cycles.
  - CLEAR -> IDLE after address DEPTH-1 is written. clr_done pulses for 1 cycle coincident with clr_busy falling.
  - clr_req while in CLEAR is ignored; there is no restart.
  - While clr_busy=1: wr_en and rd_en are ignored, no read is launched, and rd_valid stays 0. Reads already in the pipeline when the clear starts still complete.
  - clr_req and wr_en/rd_en in the same IDLE cycle: the access is performed and the clear starts the following cycle.
- Reset mid-clear: the FSM returns to IDLE with clr_busy=0 and no clr_done. The array is left partially cleared.
- Reset mid-read: the pipeline is flushed and rd_valid=0.
- Address arithmetic: the clear counter is ADDR_W+1 bits wide so it can detect wrap. No other wrap handling is needed because addresses are full-range.

Decomposition:
- Package ub_pkg holds:
  - UB_LANES and UB_LANE_W defaults;
  - the word-width function W = LANES*LANE_W;
  - the clear-state enum ub_clr_state_t {UB_IDLE, UB_CLEAR}.
- Sub-module ub_clear_ctrl contains the FSM, counter and clr_busy/clr_done logic. It outputs clear address and clear write enable, which are muxed ahead of the array write port.
- Top level contains the array, strobe merge, collision bypass and read pipeline.

Test Plan:
- Reset, then write addr 5 = 0x0807060504030201 with strb=0xFF, then read addr 5 -> rd_valid after 1 cycle (RD_LATENCY=1), rd_data=0x0807060504030201. Repeat with RD_LATENCY=2 -> valid after 2 cycles.
- Partial strobe: addr 5 holds 0x0807060504030201; write 0xFFFFFFFFFFFFFFFF with strb=0x0F; read -> 0x08070605FFFFFFFF.
- Collision: addr 9 holds 0x1111111111111111; same cycle rd_en and wr_en to addr 9 with data 0x2222222222222222, strb=0xF0 -> rd_data=0x2222222211111111.
- Streaming: read addrs 0..15 on consecutive cycles after writing addr*0x0101010101010101 -> 16 consecutive valid cycles with matching data in order.
- Clear: fill addrs 0, 512, 1023 with nonzero data; pulse clr_req -> clr_busy high for exactly 1024 cycles; clr_done pulses once; reads of 0, 512, 1023 return 0. A wr_en issued during busy has no effect.
- Reset mid-clear: assert rst_n=0 at clear cycle 100 -> clr_busy=0 immediately and no clr_done. Addr 50 reads 0; addr 900 keeps its previous nonzero data.
